// File: rtl/popcnt_sched_pkg.sv
// popcnt_sched shared package: requester ids, pipeline tag layout,
// and the popcount width helper used by bit_cntr.
package popcnt_sched_pkg;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic vld;
        logic id;
        logic last;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcnt_sched_bit_cntr.sv
// bit_cntr: pipelined popcount. Granule counts are registered first, then
// summed and delayed so o_Sum is registered CNT_LATENCY (>=2) edges later.
module bit_cntr
    import popcnt_sched_pkg::*;
#(
    parameter int VECTOR_WIDTH  = 50,
    parameter int GRANULE_WIDTH = 6,
    parameter int CNT_LATENCY   = 3,
    parameter int CNT_WIDTH     = cnt_width(VECTOR_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [VECTOR_WIDTH-1:0] i_Vector,
    output logic [CNT_WIDTH-1:0]    o_Sum
);

    localparam int NG  = (VECTOR_WIDTH + GRANULE_WIDTH - 1) / GRANULE_WIDTH;
    localparam int GCW = $clog2(GRANULE_WIDTH + 1);
    localparam int PW  = NG * GRANULE_WIDTH;

    logic [PW-1:0]        w_Pad;
    logic [GCW-1:0]       w_Gran [NG];
    logic [GCW-1:0]       r_Gran [NG];
    logic [CNT_WIDTH-1:0] w_Total;
    logic [CNT_WIDTH-1:0] r_Pipe [CNT_LATENCY-1];

    assign w_Pad = PW'(i_Vector);

    // Count ones inside each granule of the zero-padded word
    always_comb begin
        for (int g = 0; g < NG; g++) begin
            w_Gran[g] = '0;
            for (int b = 0; b < GRANULE_WIDTH; b++) begin
                w_Gran[g] = w_Gran[g] + GCW'(w_Pad[g*GRANULE_WIDTH+b]);
            end
        end
    end

    // First stage: register the granule counts
    always_ff @(posedge clk) begin
        for (int g = 0; g < NG; g++) begin
            if (!rstn) r_Gran[g] <= '0;
            else       r_Gran[g] <= w_Gran[g];
        end
    end

    // Reduce the registered granule counts to the word total
    always_comb begin
        w_Total = '0;
        for (int g = 0; g < NG; g++) begin
            w_Total = w_Total + CNT_WIDTH'(r_Gran[g]);
        end
    end

    // Remaining stages: delay the total to the advertised latency
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < CNT_LATENCY - 1; i++) r_Pipe[i] <= '0;
        end else begin
            r_Pipe[0] <= w_Total;
            for (int i = 1; i < CNT_LATENCY - 1; i++) r_Pipe[i] <= r_Pipe[i-1];
        end
    end

    assign o_Sum = r_Pipe[CNT_LATENCY-2];

endmodule

// File: rtl/popcnt_sched.sv
// popcnt_sched: round-robin sharing of one bit_cntr between streams A/B.
// Define POPCNT_SCHED_OVF_EN for saturating accumulators and o_OvfA/o_OvfB.
module popcnt_sched
    import popcnt_sched_pkg::*;
#(
    parameter int VECTOR_WIDTH  = 50,
    parameter int GRANULE_WIDTH = 6,
    parameter int CNT_LATENCY   = 3,
    parameter int CNT_WIDTH     = 7,
    parameter int ACC_WIDTH     = 12
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [VECTOR_WIDTH-1:0] i_VecA,
    input  logic [VECTOR_WIDTH-1:0] i_VecB,
    input  logic                    i_ValidA,
    input  logic                    i_ValidB,
    input  logic                    i_LastA,
    input  logic                    i_LastB,
    output logic                    o_ReadyA,
    output logic                    o_ReadyB,
    output logic [ACC_WIDTH-1:0]    o_SumA,
    output logic [ACC_WIDTH-1:0]    o_SumB,
    output logic                    o_SumValidA,
    output logic                    o_SumValidB
`ifdef POPCNT_SCHED_OVF_EN
   ,output logic                    o_OvfA,
    output logic                    o_OvfB
`endif
);

`ifdef POPCNT_SCHED_OVF_EN
    localparam int TW = ((ACC_WIDTH > CNT_WIDTH) ? ACC_WIDTH : CNT_WIDTH) + 1;
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;
`else
    localparam int TW = ACC_WIDTH;
`endif

    logic                    r_Rr;
    logic                    w_GntA;
    logic                    w_GntB;
    logic [VECTOR_WIDTH-1:0] w_Vec;
    tag_t                    w_TagIn;
    tag_t                    r_Tag [CNT_LATENCY];
    tag_t                    w_Ret;
    logic [CNT_WIDTH-1:0]    w_Sum;
    logic [ACC_WIDTH-1:0]    r_Acc [2];
    logic [TW-1:0]           w_Tot;
    logic [ACC_WIDTH-1:0]    w_New;
    logic [ACC_WIDTH-1:0]    r_SumA;
    logic [ACC_WIDTH-1:0]    r_SumB;
    logic                    r_SvA;
    logic                    r_SvB;
`ifdef POPCNT_SCHED_OVF_EN
    logic                    w_Sat;
    logic                    r_OvfA;
    logic                    r_OvfB;
`endif

    // Grant: lone requester wins, contention resolved by rr
    always_comb begin
        w_GntA = 1'b0;
        w_GntB = 1'b0;
        if (i_ValidA && (!i_ValidB || r_Rr == REQ_A)) w_GntA = 1'b1;
        else if (i_ValidB)                             w_GntB = 1'b1;
    end

    assign o_ReadyA = w_GntA;
    assign o_ReadyB = w_GntB;

    // Issue mux and tag for the granted word; idle cycles feed zeros
    always_comb begin
        w_Vec = '0;
        if (w_GntA)      w_Vec = i_VecA;
        else if (w_GntB) w_Vec = i_VecB;
        w_TagIn.vld  = w_GntA | w_GntB;
        w_TagIn.id   = w_GntB ? REQ_B : REQ_A;
        w_TagIn.last = w_GntA ? i_LastA : (w_GntB & i_LastB);
    end

    // Round-robin pointer flips to the other requester after each grant
    always_ff @(posedge clk) begin
        if (!rstn)       r_Rr <= REQ_A;
        else if (w_GntA) r_Rr <= REQ_B;
        else if (w_GntB) r_Rr <= REQ_A;
    end

    bit_cntr #(
        .VECTOR_WIDTH  (VECTOR_WIDTH),
        .GRANULE_WIDTH (GRANULE_WIDTH),
        .CNT_LATENCY   (CNT_LATENCY),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_cntr (
        .clk      (clk),
        .rstn     (rstn),
        .i_Vector (w_Vec),
        .o_Sum    (w_Sum)
    );

    // Tag shift register keeps id/last aligned with the counter output
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < CNT_LATENCY; i++) r_Tag[i] <= '0;
        end else begin
            r_Tag[0] <= w_TagIn;
            for (int i = 1; i < CNT_LATENCY; i++) r_Tag[i] <= r_Tag[i-1];
        end
    end

    assign w_Ret = r_Tag[CNT_LATENCY-1];

    // Next accumulator value for the retiring id (wrap or saturate)
    always_comb begin
        w_Tot = TW'(r_Acc[w_Ret.id]) + TW'(w_Sum);
`ifdef POPCNT_SCHED_OVF_EN
        w_Sat = (w_Tot > TW'(ACC_MAX));
        w_New = w_Sat ? ACC_MAX : w_Tot[ACC_WIDTH-1:0];
`else
        w_New = w_Tot;
`endif
    end

    // Retire: accumulate, and on last publish the total and clear
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_Acc[0] <= '0;
            r_Acc[1] <= '0;
            r_SumA   <= '0;
            r_SumB   <= '0;
            r_SvA    <= 1'b0;
            r_SvB    <= 1'b0;
`ifdef POPCNT_SCHED_OVF_EN
            r_OvfA   <= 1'b0;
            r_OvfB   <= 1'b0;
`endif
        end else begin
            r_SvA <= 1'b0;
            r_SvB <= 1'b0;
            if (w_Ret.vld) begin
                if (w_Ret.last) begin
                    r_Acc[w_Ret.id] <= '0;
                    if (w_Ret.id == REQ_A) begin
                        r_SumA <= w_New;
                        r_SvA  <= 1'b1;
                    end else begin
                        r_SumB <= w_New;
                        r_SvB  <= 1'b1;
                    end
                end else begin
                    r_Acc[w_Ret.id] <= w_New;
                end
`ifdef POPCNT_SCHED_OVF_EN
                if (w_Sat && w_Ret.id == REQ_A) r_OvfA <= 1'b1;
                if (w_Sat && w_Ret.id == REQ_B) r_OvfB <= 1'b1;
`endif
            end
        end
    end

    assign o_SumA      = r_SumA;
    assign o_SumB      = r_SumB;
    assign o_SumValidA = r_SvA;
    assign o_SumValidB = r_SvB;
`ifdef POPCNT_SCHED_OVF_EN
    assign o_OvfA      = r_OvfA;
    assign o_OvfB      = r_OvfB;
`endif

endmodule

// File: tb/tb_popcnt_sched.sv
// Scoreboard bench for popcnt_sched: driver pushes expected totals and
// pulse cycles on last-word accept, a monitor pops them on each SumValid.
module tb_popcnt_sched;

    localparam int VW = 50;
    localparam int L  = 3;

    typedef struct {
        logic [VW-1:0] v;
        bit            last;
        int            exp;
    } word_t;

    typedef struct {
        int sum;
        int cyc;
    } exp_t;

    logic          clk  = 1'b0;
    logic          rstn = 1'b0;
    logic [VW-1:0] i_VecA, i_VecB;
    logic          i_ValidA, i_ValidB, i_LastA, i_LastB;
    logic          o_ReadyA, o_ReadyB;
    logic [11:0]   o_SumA, o_SumB;
    logic          o_SumValidA, o_SumValidB;

    logic [VW-1:0] s_Vec6;
    logic          s_Valid6, s_Last6, s_Ready6, s_Sv6;
    logic [5:0]    s_Sum6;
    logic          n_ReadyB6, n_SvB6;
    logic [5:0]    n_SumB6;
    logic [VW-1:0] z_Vec;
    logic          z_Bit;

`ifdef POPCNT_SCHED_OVF_EN
    logic o_OvfA, o_OvfB, s_Ovf6, n_OvfB6;
`endif

    int cyc    = 0;
    int n_chk  = 0;
    int n_fail = 0;

    word_t wqA[$], wqB[$], wq6[$];
    exp_t  eA[$], eB[$], e6[$];
    bit    acc_log[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    popcnt_sched dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_VecA      (i_VecA),
        .i_VecB      (i_VecB),
        .i_ValidA    (i_ValidA),
        .i_ValidB    (i_ValidB),
        .i_LastA     (i_LastA),
        .i_LastB     (i_LastB),
        .o_ReadyA    (o_ReadyA),
        .o_ReadyB    (o_ReadyB),
        .o_SumA      (o_SumA),
        .o_SumB      (o_SumB),
        .o_SumValidA (o_SumValidA),
        .o_SumValidB (o_SumValidB)
`ifdef POPCNT_SCHED_OVF_EN
       ,.o_OvfA      (o_OvfA),
        .o_OvfB      (o_OvfB)
`endif
    );

    popcnt_sched #(.ACC_WIDTH(6)) dut6 (
        .clk         (clk),
        .rstn        (rstn),
        .i_VecA      (s_Vec6),
        .i_VecB      (z_Vec),
        .i_ValidA    (s_Valid6),
        .i_ValidB    (z_Bit),
        .i_LastA     (s_Last6),
        .i_LastB     (z_Bit),
        .o_ReadyA    (s_Ready6),
        .o_ReadyB    (n_ReadyB6),
        .o_SumA      (s_Sum6),
        .o_SumB      (n_SumB6),
        .o_SumValidA (s_Sv6),
        .o_SumValidB (n_SvB6)
`ifdef POPCNT_SCHED_OVF_EN
       ,.o_OvfA      (s_Ovf6),
        .o_OvfB      (n_OvfB6)
`endif
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: unexpected result pulse at cycle %0d", nm, cyc);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((wqA.size() + wqB.size() + wq6.size() +
                eA.size() + eB.size() + e6.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: queues not empty after %0d cycles", n);
        end
        repeat (3) @(negedge clk);
    endtask

    // Driver: present queue heads each cycle, record accepts
    initial begin : drv
        forever begin
            @(negedge clk);
            i_ValidA = (wqA.size() != 0);
            i_VecA   = i_ValidA ? wqA[0].v : '0;
            i_LastA  = i_ValidA ? wqA[0].last : 1'b0;
            i_ValidB = (wqB.size() != 0);
            i_VecB   = i_ValidB ? wqB[0].v : '0;
            i_LastB  = i_ValidB ? wqB[0].last : 1'b0;
            s_Valid6 = (wq6.size() != 0);
            s_Vec6   = s_Valid6 ? wq6[0].v : '0;
            s_Last6  = s_Valid6 ? wq6[0].last : 1'b0;
            #1;
            chk("ready/valid rule",
                {o_ReadyA & ~i_ValidA, o_ReadyB & ~i_ValidB, o_ReadyA & o_ReadyB}, 0);
            if (o_ReadyA && i_ValidA) begin
                if (wqA[0].last) eA.push_back(exp_t'{wqA[0].exp, cyc + L + 1});
                acc_log.push_back(1'b0);
                void'(wqA.pop_front());
            end
            if (o_ReadyB && i_ValidB) begin
                if (wqB[0].last) eB.push_back(exp_t'{wqB[0].exp, cyc + L + 1});
                acc_log.push_back(1'b1);
                void'(wqB.pop_front());
            end
            if (s_Ready6 && s_Valid6) begin
                if (wq6[0].last) e6.push_back(exp_t'{wq6[0].exp, cyc + L + 1});
                void'(wq6.pop_front());
            end
        end
    end

    // Monitor: compare every result pulse against the scoreboard
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_SumValidA) begin
                if (eA.size() == 0) unexp("SumValidA");
                else begin
                    e = eA.pop_front();
                    chk("SumA value", o_SumA, e.sum);
                    chk("SumA cycle", cyc, e.cyc);
                end
            end
            if (o_SumValidB) begin
                if (eB.size() == 0) unexp("SumValidB");
                else begin
                    e = eB.pop_front();
                    chk("SumB value", o_SumB, e.sum);
                    chk("SumB cycle", cyc, e.cyc);
                end
            end
            if (s_Sv6) begin
                if (e6.size() == 0) unexp("SumValid6");
                else begin
                    e = e6.pop_front();
                    chk("Sum6 value", s_Sum6, e.sum);
                    chk("Sum6 cycle", cyc, e.cyc);
                end
            end
            if (n_SvB6) unexp("SumValidB6");
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit exp_ord [6];
        int n0;
        int n;
        int s6;

        z_Vec    = '0;
        z_Bit    = 1'b0;
        i_VecA   = '0;
        i_VecB   = '0;
        i_ValidA = 1'b0;
        i_ValidB = 1'b0;
        i_LastA  = 1'b0;
        i_LastB  = 1'b0;
        s_Vec6   = '0;
        s_Valid6 = 1'b0;
        s_Last6  = 1'b0;
        exp_ord  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset SumA", o_SumA, 0);
        chk("reset SumB", o_SumB, 0);
        chk("reset SumValid", {o_SumValidA, o_SumValidB}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // A-only two-word fingerprint: 48 + 24 = 72; ACC_WIDTH=6 copy: 48+48
        wqA.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b0, 0});
        wqA.push_back(word_t'{50'h0F0F0F0F0F0F0, 1'b1, 72});
`ifdef POPCNT_SCHED_OVF_EN
        s6 = 63;
`else
        s6 = 32;
`endif
        wq6.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b0, 0});
        wq6.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b1, s6});
        wait_idle();
        chk("SumB untouched", o_SumB, 0);

        // B-only single-word fingerprints, back to back
        wqB.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b1, 48});
        wqB.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b1, 48});
        @(negedge clk);
        #2;
        chk("ReadyB immediate", o_ReadyB, 1);
        chk("ReadyA idle", o_ReadyA, 0);
        wait_idle();

        // Both streams contending: grants alternate starting with A
        acc_log = {};
        for (int i = 0; i < 3; i++) begin
            wqA.push_back(word_t'{50'h0666666666666, i == 2, 72});
            wqB.push_back(word_t'{50'h0111111111111, i == 2, 36});
        end
        wait_idle();
        chk("grant count", acc_log.size(), 6);
        for (int i = 0; i < 6 && i < acc_log.size(); i++) begin
            chk($sformatf("grant order %0d", i), acc_log[i], exp_ord[i]);
        end

        // Reset one cycle after a non-last A word is accepted
        n0 = acc_log.size();
        n  = 0;
        wqA.push_back(word_t'{50'h0FFFFFFFFFFFF, 1'b0, 0});
        while (acc_log.size() == n0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("reset-test accept", acc_log.size(), n0 + 1);
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid reset SumA", o_SumA, 0);
        chk("mid reset SumB", o_SumB, 0);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        wqA.push_back(word_t'{50'h0111111111111, 1'b1, 12});
        wait_idle();

`ifdef POPCNT_SCHED_OVF_EN
        chk("OvfA", o_OvfA, 0);
        chk("OvfB", o_OvfB, 0);
        chk("Ovf6 after reset", s_Ovf6, 0);
`endif
        chk("pending A", eA.size(), 0);
        chk("pending B", eB.size(), 0);
        chk("pending 6", e6.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

`ifdef POPCNT_SCHED_OVF_EN
    // Sticky overflow on the narrow instance must be set by its own result
    initial begin : ovf6
        int n = 0;
        while (!s_Sv6 && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("Ovf6 sticky", s_Ovf6, 1);
    end
`endif

endmodule
